// File: rtl/nn_pkg.sv
// nn_pkg
// Shared definitions for the sequential linear layer:
//   state_e     - controller state encoding
//   clog2_min1  - address/index width helper (never narrower than 1 bit)
//   requant     - round, shift, optional ReLU and saturate one accumulator value
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2
  } state_e;

  // Working width of the requantiser; wide enough for any accumulator this
  // block can be configured with.
  localparam int QW = 64;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Round-half-up, arithmetic shift by frac, optional clamp of negatives,
  // then saturate to the signed dw-bit range. Result is returned at full
  // width; the caller keeps the low dw bits.
  function automatic logic signed [QW-1:0] requant(
    input logic signed [QW-1:0] acc,
    input int                   frac,
    input bit                   relu,
    input int                   dw
  );
    logic signed [QW-1:0] v;
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    v = acc;
    if (frac > 0) v = v + (64'sd1 <<< (frac - 1));
    v  = v >>> frac;
    if (relu && (v < 0)) v = '0;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi)      v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_linear_seq_mem.sv
// nn_linear_seq_mem
// Coefficient store for the linear layer: OUT_N*IN_N weights of DW bits and
// OUT_N biases of 2*DW bits, cleared on reset.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   wr_en             - write strobe (already qualified by the caller)
//   wr_bias           - 1 targets the bias store, 0 the weight store
//   wr_addr           - weight index o*IN_N+i or bias index o
//   wr_data           - weight in low DW bits, or full-width bias
//   rd_o, rd_i        - combinational read coordinates
//   w_rd              - weight[rd_o][rd_i]
//   b_rd              - bias[rd_o], write-through when written this cycle
module nn_linear_seq_mem
  import nn_pkg::*;
#(
  parameter int IN_N  = 4,
  parameter int OUT_N = 4,
  parameter int DW    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   wr_en,
  input  logic                                   wr_bias,
  input  logic [clog2_min1(OUT_N*IN_N)-1:0]      wr_addr,
  input  logic [2*DW-1:0]                        wr_data,
  input  logic [clog2_min1(OUT_N)-1:0]           rd_o,
  input  logic [clog2_min1(IN_N)-1:0]            rd_i,
  output logic signed [DW-1:0]                   w_rd,
  output logic signed [2*DW-1:0]                 b_rd
);

  localparam int ADW = clog2_min1(OUT_N*IN_N);
  localparam int OW  = clog2_min1(OUT_N);

  logic [DW-1:0]   w_q [OUT_N*IN_N];
  logic [DW-1:0]   w_d [OUT_N*IN_N];
  logic [2*DW-1:0] b_q [OUT_N];
  logic [2*DW-1:0] b_d [OUT_N];

  logic           w_ok;
  logic           b_ok;
  logic           r_ok;
  logic [ADW-1:0] widx;

  assign w_ok = wr_en & ~wr_bias & ({1'b0, wr_addr} < (ADW+1)'(OUT_N*IN_N));
  assign b_ok = wr_en &  wr_bias & ({1'b0, wr_addr} < (ADW+1)'(OUT_N));
  assign r_ok = {1'b0, rd_o} < (OW+1)'(OUT_N);
  assign widx = ADW'(rd_o * IN_N + rd_i);

  always_comb begin
    w_d = w_q;
    b_d = b_q;
    if (w_ok) w_d[wr_addr] = wr_data[DW-1:0];
    if (b_ok) b_d[wr_addr[OW-1:0]] = wr_data;
  end

  // Bias is forwarded from the write port so a bias written on the same edge
  // that accepts start is already the value loaded into the accumulator.
  always_comb begin
    w_rd = '0;
    b_rd = '0;
    if (r_ok) begin
      w_rd = w_q[widx];
      b_rd = b_q[rd_o];
    end
    if (b_ok && r_ok && (wr_addr == ADW'(rd_o))) b_rd = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OUT_N*IN_N; k++) w_q[k] <= '0;
      for (int k = 0; k < OUT_N; k++)      b_q[k] <= '0;
    end else begin
      w_q <= w_d;
      b_q <= b_d;
    end
  end

endmodule

// File: rtl/nn_linear_seq.sv
// nn_linear_seq
// Sequential fully-connected layer: one multiply-accumulate per cycle, one
// requantise/write-back cycle per output neuron.
// Ports:
//   clk, rst_n                          - clock, async active-low reset
//   start                               - request one evaluation (ignored while busy)
//   busy, done                          - in progress / one-cycle completion pulse
//   in_vec                              - IN_N signed features, captured on start
//   out_vec                             - OUT_N registered signed results
//   wr_en, wr_bias, wr_addr, wr_data    - coefficient write port (idle only)
//
// state | meaning
// IDLE  | waiting for start; coefficient writes accepted
// MAC   | accumulating in[i]*w[o][i], one product per cycle
// WB    | requantise accumulator into out_vec slot o, then next neuron or finish
module nn_linear_seq
  import nn_pkg::*;
#(
  parameter int IN_N  = 4,
  parameter int OUT_N = 4,
  parameter int DW    = 8,
  parameter int FRAC  = 0,
  parameter int RELU  = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  input  logic [IN_N*DW-1:0]                  in_vec,
  output logic [OUT_N*DW-1:0]                 out_vec,
  input  logic                                wr_en,
  input  logic                                wr_bias,
  input  logic [clog2_min1(OUT_N*IN_N)-1:0]   wr_addr,
  input  logic [2*DW-1:0]                     wr_data
);

  localparam int AW = 2*DW + $clog2(IN_N) + 1;
  localparam int IW = clog2_min1(IN_N);
  localparam int OW = clog2_min1(OUT_N);

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fin_q, fin_d;
  logic [IW-1:0]         i_q, i_d;
  logic [OW-1:0]         o_q, o_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [IN_N*DW-1:0]    in_q, in_d;
  logic [DW-1:0]         out_q [OUT_N];
  logic [DW-1:0]         out_d [OUT_N];

  logic                  wr_ok;
  logic [OW-1:0]         rd_o;
  logic signed [DW-1:0]  w_rd;
  logic signed [2*DW-1:0] b_rd;
  logic signed [DW-1:0]  x_cur;
  logic signed [2*DW-1:0] prod;
  logic [DW-1:0]         rq;

  assign wr_ok = wr_en & ~busy_q;
  // In WB the bias for the following neuron is needed for the MAC entry load.
  assign rd_o  = (state_q == WB) ? o_q + OW'(1) : o_q;

  nn_linear_seq_mem #(
    .IN_N  (IN_N),
    .OUT_N (OUT_N),
    .DW    (DW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_bias (wr_bias),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_o    (rd_o),
    .rd_i    (i_q),
    .w_rd    (w_rd),
    .b_rd    (b_rd)
  );

  always_comb begin
    x_cur = '0;
    for (int k = 0; k < IN_N; k++) begin
      if (i_q == IW'(k)) x_cur = in_q[k*DW +: DW];
    end
    prod = (2*DW)'(x_cur) * (2*DW)'(w_rd);
    rq   = DW'(requant(QW'(acc_q), FRAC, RELU != 0, DW));
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    o_d     = o_q;
    acc_d   = acc_q;
    in_d    = in_q;
    out_d   = out_q;
    fin_d   = 1'b0;
    done_d  = fin_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MAC;
          in_d    = in_vec;
          i_d     = '0;
          o_d     = '0;
          acc_d   = AW'(b_rd);
        end
      end
      MAC: begin
        acc_d = acc_q + AW'(prod);
        if (i_q == IW'(IN_N - 1)) begin
          state_d = WB;
          i_d     = '0;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      WB: begin
        for (int k = 0; k < OUT_N; k++) begin
          if (o_q == OW'(k)) out_d[k] = rq;
        end
        if (o_q == OW'(OUT_N - 1)) begin
          state_d = IDLE;
          o_d     = '0;
          fin_d   = 1'b1;
        end else begin
          state_d = MAC;
          o_d     = o_q + OW'(1);
          acc_d   = AW'(b_rd);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fin_q   <= 1'b0;
      i_q     <= '0;
      o_q     <= '0;
      acc_q   <= '0;
      in_q    <= '0;
      for (int k = 0; k < OUT_N; k++) out_q[k] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fin_q   <= fin_d;
      i_q     <= i_d;
      o_q     <= o_d;
      acc_q   <= acc_d;
      in_q    <= in_d;
      out_q   <= out_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

  for (genvar g = 0; g < OUT_N; g++) begin : g_out
    assign out_vec[g*DW +: DW] = out_q[g];
  end

endmodule

// File: doc/nn_linear_seq.md
NN_LINEAR_SEQ -- requirements
Module: nn_linear_seq

Interface
REQ-001 SHALL have parameter IN_N, default 4, meaning number of input features (>=1).
REQ-002 SHALL have parameter OUT_N, default 4, meaning number of output neurons (>=1).
REQ-003 SHALL have parameter DW, default 8, meaning signed two's-complement activation and weight width.
REQ-004 SHALL have parameter FRAC, default 0, meaning requantisation right-shift (0..2*DW-1).
REQ-005 SHALL have parameter RELU, default 0, meaning 1 fuses ReLU before saturation.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-008 SHALL have port start, input, 1, meaning request one layer evaluation.
REQ-009 SHALL have port busy, output, 1, meaning evaluation in progress.
REQ-010 SHALL have port done, output, 1, meaning one-cycle completion pulse.
REQ-011 SHALL have port in_vec, input, IN_N*DW, meaning signed inputs, feature i at bits [i*DW +: DW].
REQ-012 SHALL have port out_vec, output, OUT_N*DW, meaning registered signed results, neuron o at [o*DW +: DW].
REQ-013 SHALL have port wr_en, input, 1, meaning coefficient write strobe.
REQ-014 SHALL have port wr_bias, input, 1, meaning 1 selects the bias store, 0 the weight store.
REQ-015 SHALL have port wr_addr, input, clog2(OUT_N*IN_N) (min 1), meaning weight index o*IN_N+i, or bias index o.
REQ-016 SHALL have port wr_data, input, 2*DW, meaning weight in low DW bits, or full-width signed bias.

Function
REQ-017 SHALL implement FSM states IDLE, MAC, WB: IDLE->MAC on start; MAC->WB after IN_N MAC cycles; WB->MAC for next neuron; WB->IDLE after neuron OUT_N-1.
REQ-018 SHALL capture in_vec into an internal register on the edge that accepts start; later in_vec changes SHALL NOT affect the result.
REQ-019 SHALL ignore start while busy=1; busy SHALL be 1 in MAC and WB.
REQ-020 SHALL load the accumulator with bias[o], sign-extended, on entry to MAC, then add in[i]*w[o][i] (signed DW x DW) for i=0..IN_N-1, one product per cycle.
REQ-021 SHALL size the accumulator 2*DW+clog2(IN_N)+1 bits so that no intermediate overflow occurs.
REQ-022 SHALL requantise in WB: add 2^(FRAC-1) if FRAC>0; arithmetic shift right by FRAC; clamp negatives to 0 if RELU=1; saturate to [-2^(DW-1), 2^(DW-1)-1]; write to out_vec slot o.
REQ-023 SHALL pulse done for exactly one cycle, on the edge after the final WB, with out_vec complete; total latency start-edge to done-edge = OUT_N*(IN_N+1)+1 cycles.
REQ-024 SHALL hold out_vec stable between evaluations; a slot SHALL change only during its own WB cycle.
REQ-025 SHALL perform coefficient writes only when busy=0; wr_en while busy=1 SHALL be dropped.
REQ-026 SHALL give priority to start when wr_en and start coincide in IDLE; the write takes effect and the evaluation uses the new value.
REQ-027 SHALL drop writes with out-of-range wr_addr (>=OUT_N*IN_N for weights, >=OUT_N for biases).

Reset
REQ-028 SHALL, on rst_n low at any time including mid-evaluation, force state IDLE, busy=0, done=0, out_vec=0, counters=0, accumulator=0, with no done pulse.
REQ-029 SHALL clear all weights and biases to 0 on reset.

Structure
REQ-030 SHALL place the FSM state enum, the clog2-min-1 helper, and the saturate/requantise function in shared package nn_pkg.
REQ-031 SHALL put coefficient storage (weight/bias arrays, write port, combinational read by (o,i)) in sub-module nn_linear_seq_mem.

Verification
REQ-032 SHALL cover: IN_N=1, OUT_N=4, DW=8, FRAC=0, weights 127,-127,127,-127, biases 0, in=1 -> out 127,-127,127,-127, done at cycle 9.
REQ-033 SHALL cover: same weights, in=2 -> outputs saturate to 127,-128,127,-128; with RELU=1 -> 127,0,127,0.
REQ-034 SHALL cover: IN_N=4, OUT_N=1, FRAC=2, weights all 3, bias 1, in 1,2,3,4 -> acc 31, rounded (31+2)>>2 = 8, done at cycle 6.
REQ-035 SHALL cover: start pulsed again mid-run and in_vec changed after start -> single done, result from captured inputs.
REQ-036 SHALL cover: rst_n asserted during MAC -> busy=0, out_vec=0 immediately; no done; a fresh start after release gives correct results with reloaded coefficients.
REQ-037 SHALL cover: wr_en during busy and to out-of-range addresses -> storage unchanged, verified by a subsequent evaluation.
